// File: rtl/pb_cnt_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pb_cnt_ctrl_if
//  Description : Signal bundle between the pushbutton sequencing controller
//                and the board pin / up_dwn_cnt4 counter it drives.
//  Revision    : 1.0  initial release
// ============================================================================
interface pb_cnt_ctrl_if;
  logic       PB_n;     // raw pushbutton, active low, asynchronous to clk
  logic [3:0] cnt;      // counter value fed back from up_dwn_cnt4
  logic       en;       // one-cycle step pulse to the counter
  logic       dwn;      // count direction (0 = up, 1 = down)
  logic       pb_held;  // debounced pressed level

  // Controller side
  modport master (
    input  PB_n,
    input  cnt,
    output en,
    output dwn,
    output pb_held
  );

  // Board pin / counter side
  modport slave (
    output PB_n,
    output cnt,
    input  en,
    input  dwn,
    input  pb_held
  );
endinterface
`default_nettype wire

// File: rtl/pb_cnt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pb_cnt_ctrl
//  Description : Pushbutton sequencing controller for a 4-bit up/down
//                counter. Synchronises and debounces the button, issues one
//                step pulse per release and ping-pongs the count direction
//                between CNT_MIN and CNT_MAX so the counter never wraps.
//  Options     : define AUTO_RPT_EN to add hold-to-repeat stepping
//                (RPT_DLY / RPT_PER parameters and the RPT state).
//  Revision    : 1.0  initial release
// ============================================================================
module pb_cnt_ctrl #(
  parameter int         DB_CYCLES = 50000,
  parameter logic [3:0] CNT_MAX   = 4'd15,
  parameter logic [3:0] CNT_MIN   = 4'd0
`ifdef AUTO_RPT_EN
  ,
  parameter int         RPT_DLY   = 25000000,
  parameter int         RPT_PER   = 5000000
`endif
) (
  input wire logic      clk,
  input wire logic      rst_n,
  pb_cnt_ctrl_if.master bus
);

  localparam int              c_db_w    = $clog2(DB_CYCLES);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DB_CYCLES - 1);

`ifdef AUTO_RPT_EN
  localparam int               c_tmr_w   = $clog2((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER);
  localparam logic [c_tmr_w-1:0] c_dly_last = c_tmr_w'(RPT_DLY - 1);
  localparam logic [c_tmr_w-1:0] c_per_last = c_tmr_w'(RPT_PER - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1
`ifdef AUTO_RPT_EN
    ,
    ST_RPT   = 2'd2
`endif
  } state_t;

  logic [1:0]        r_sync;
  logic [c_db_w-1:0] r_db_cnt;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_pending;
  logic              r_dwn;
  logic              w_pb_pressed;
  logic              w_db_level;
  logic              w_db_toggle;
  logic              w_req;
  logic              w_pb_held;
  logic              w_hi;
  logic              w_lo;
  logic              w_turn;
  logic              w_en;
`ifdef AUTO_RPT_EN
  logic [c_tmr_w-1:0] r_tmr;
  logic               w_tmr_clr;
`endif

  // The FSM state is the debounced level: any non-idle state means pressed.
  assign w_pb_pressed = ~r_sync[1];
  assign w_db_level   = (r_state != ST_IDLE);
  assign w_db_toggle  = (w_pb_pressed != w_db_level) && (r_db_cnt == c_db_last);

  // Out-of-range values fold into the turn-around test so dwn is forced back
  // toward the legal range and en is held off while it moves.
  assign w_hi   = (bus.cnt >= CNT_MAX);
  assign w_lo   = (bus.cnt <= CNT_MIN);
  assign w_turn = (w_hi && !r_dwn) || (w_lo && r_dwn);
  assign w_en   = r_pending && !w_turn;

  assign bus.en      = w_en;
  assign bus.dwn     = r_dwn;
  assign bus.pb_held = w_pb_held;

  // Two-flop synchroniser for the asynchronous button pin (idles released)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], bus.PB_n};
  end

  // Stability counter: runs only while the input disagrees with the debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_db_cnt <= '0;
    else if ((w_pb_pressed == w_db_level) || w_db_toggle) r_db_cnt <= '0;
    else                                                r_db_cnt <= r_db_cnt + c_db_w'(1);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state, step requests and pressed level
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_pb_held   = 1'b0;
`ifdef AUTO_RPT_EN
    w_tmr_clr   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_db_toggle) w_state_nxt = ST_PRESS;
      end
      ST_PRESS: begin
        w_pb_held = 1'b1;
        if (w_db_toggle) begin
          w_state_nxt = ST_IDLE;
          w_req       = 1'b1;
        end
`ifdef AUTO_RPT_EN
        else if (r_tmr == c_dly_last) begin
          w_state_nxt = ST_RPT;
          w_req       = 1'b1;
          w_tmr_clr   = 1'b1;
        end
`endif
      end
`ifdef AUTO_RPT_EN
      ST_RPT: begin
        w_pb_held = 1'b1;
        // Release wins over a coincident repeat tick: no step on release.
        if (w_db_toggle) begin
          w_state_nxt = ST_IDLE;
        end else if (r_tmr == c_per_last) begin
          w_req     = 1'b1;
          w_tmr_clr = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef AUTO_RPT_EN
  // Hold timer: counts while pressed, restarts on each repeat step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_tmr <= '0;
    else if (r_state == ST_IDLE || w_tmr_clr) r_tmr <= '0;
    else                                    r_tmr <= r_tmr + c_tmr_w'(1);
  end
`endif

  // Single outstanding step request; new requests merge into a pending one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= 1'b0;
    else        r_pending <= w_req || (r_pending && !w_en);
  end

  // Direction flips the cycle after an end value is seen; never while en=1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_dwn <= 1'b0;
    else if (w_hi && !r_dwn) r_dwn <= 1'b1;
    else if (w_lo && r_dwn)  r_dwn <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_pb_cnt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_cnt_ctrl
//  Description : Directed self-checking bench for pb_cnt_ctrl with a
//                behavioural 4-bit up/down counter closing the cnt loop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pb_cnt_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       model_en;
  logic [3:0] m_cnt;
  logic [3:0] man_cnt;
  int         en_count;
  int         held_cycles;
  logic       wrap_seen;
  int         n_checks;
  int         n_pass;
  int         n_fail;
  int         snap_e;
  int         snap_h;

  pb_cnt_ctrl_if u_if ();

  pb_cnt_ctrl #(
    .DB_CYCLES(8)
`ifdef AUTO_RPT_EN
    ,
    .RPT_DLY(40),
    .RPT_PER(10)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  // Behavioural up_dwn_cnt4, or a bench-held value when model_en is low
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     m_cnt <= 4'd0;
    else if (model_en && u_if.en)   m_cnt <= u_if.dwn ? m_cnt - 4'd1 : m_cnt + 4'd1;
  end
  assign u_if.cnt = model_en ? m_cnt : man_cnt;

  // Pulses are counted where the counter would consume them
  always @(posedge clk) begin
    if (rst_n && u_if.en) en_count <= en_count + 1;
  end

  always @(negedge clk) begin
    if (u_if.pb_held) held_cycles <= held_cycles + 1;
  end

  initial wrap_seen = 1'b0;
  always @(posedge clk) begin
    if (rst_n && model_en && u_if.en &&
        ((!u_if.dwn && m_cnt == 4'd15) || (u_if.dwn && m_cnt == 4'd0)))
      wrap_seen <= 1'b1;
  end

  initial begin
    en_count    = 0;
    held_cycles = 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic press_release();
    u_if.PB_n = 1'b0;
    adv(14);
    u_if.PB_n = 1'b1;
    adv(14);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    model_en  = 1'b1;
    man_cnt   = 4'd0;
    u_if.PB_n = 1'b1;
    adv(1);
    check("rst_en", u_if.en, 0);
    check("rst_dwn", u_if.dwn, 0);
    check("rst_held", u_if.pb_held, 0);
    adv(2);
    rst_n = 1'b1;

    // Idle with button released
    adv(100);
    check("idle_en_count", en_count, 0);
    check("idle_dwn", u_if.dwn, 0);
    check("idle_held", u_if.pb_held, 0);

    // Clean press for 20 cycles, then release
    u_if.PB_n = 1'b0;
    adv(9);
    check("press_t9_held", u_if.pb_held, 0);
    adv(1);
    check("press_t10_held", u_if.pb_held, 1);
    adv(10);
    u_if.PB_n = 1'b1;
    adv(9);
    check("rel_t9_en", u_if.en, 0);
    check("rel_t9_held", u_if.pb_held, 1);
    adv(1);
    check("rel_t10_en", u_if.en, 1);
    check("rel_t10_held", u_if.pb_held, 0);
    adv(1);
    check("rel_t11_en", u_if.en, 0);
    check("rel_cnt", u_if.cnt, 1);
    check("rel_en_count", en_count, 1);

    // Three 5-cycle bounces never get through the debouncer
    snap_e = en_count;
    snap_h = held_cycles;
    repeat (3) begin
      u_if.PB_n = 1'b0;
      adv(5);
      u_if.PB_n = 1'b1;
      adv(5);
    end
    adv(20);
    check("bounce_held", held_cycles, snap_h);
    check("bounce_en", en_count, snap_e);

    // Count up to the top and watch the turn-around
    rst_n = 1'b0;
    adv(2);
    rst_n = 1'b1;
    adv(2);
    check("up_start_cnt", u_if.cnt, 0);
    repeat (14) press_release();
    check("up14_cnt", u_if.cnt, 14);
    check("up14_dwn", u_if.dwn, 0);
    u_if.PB_n = 1'b0;
    adv(14);
    u_if.PB_n = 1'b1;
    adv(10);
    check("up15_en", u_if.en, 1);
    adv(1);
    check("top_cnt", u_if.cnt, 15);
    check("top_dwn_before", u_if.dwn, 0);
    adv(1);
    check("top_dwn_after", u_if.dwn, 1);
    check("top_en", u_if.en, 0);
    adv(2);
    press_release();
    check("down16_cnt", u_if.cnt, 14);
    check("down16_dwn", u_if.dwn, 1);

    // Step down to the bottom and back up once
    repeat (13) press_release();
    check("down_cnt1", u_if.cnt, 1);
    press_release();
    check("bottom_cnt", u_if.cnt, 0);
    check("bottom_dwn", u_if.dwn, 0);
    press_release();
    check("rebound_cnt", u_if.cnt, 1);
    check("rebound_dwn", u_if.dwn, 0);
    check("no_wrap", wrap_seen, 0);

    // A pending request is held while the direction turns round
    man_cnt  = 4'd1;
    model_en = 1'b0;
    u_if.PB_n = 1'b0;
    adv(14);
    u_if.PB_n = 1'b1;
    adv(10);
    check("hold_pre_en", u_if.en, 1);
    snap_e  = en_count;
    man_cnt = 4'd15;
    #1;
    check("hold_turn_en", u_if.en, 0);
    check("hold_turn_dwn", u_if.dwn, 0);
    adv(1);
    check("hold_flip_dwn", u_if.dwn, 1);
    check("hold_flip_en", u_if.en, 1);
    adv(1);
    check("hold_after_en", u_if.en, 0);
    check("hold_count", en_count, snap_e + 1);

    // Reset in the middle of a hold, button kept down through reset
    u_if.PB_n = 1'b0;
    adv(12);
    check("midhold_held", u_if.pb_held, 1);
    check("midhold_dwn", u_if.dwn, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_held", u_if.pb_held, 0);
    check("midrst_dwn", u_if.dwn, 0);
    check("midrst_en", u_if.en, 0);
    model_en = 1'b1;
    adv(2);
    rst_n = 1'b1;
    adv(9);
    check("fresh_t9_held", u_if.pb_held, 0);
    adv(1);
    check("fresh_t10_held", u_if.pb_held, 1);
    u_if.PB_n = 1'b1;
    adv(10);
    check("fresh_rel_en", u_if.en, 1);

    // Reset with a request about to be consumed: it is dropped
    snap_e = en_count;
    rst_n  = 1'b0;
    #1;
    check("pendrst_en", u_if.en, 0);
    adv(2);
    rst_n = 1'b1;
    adv(20);
    check("pendrst_count", en_count, snap_e);
    check("pendrst_cnt", u_if.cnt, 0);

`ifdef AUTO_RPT_EN
    // Hold for 100 cycles: repeat after 40, then every 10, none on release
    u_if.PB_n = 1'b0;
    adv(10);
    check("rpt_held", u_if.pb_held, 1);
    snap_e = en_count;
    adv(39);
    check("rpt_t39_en", u_if.en, 0);
    adv(1);
    check("rpt_t40_en", u_if.en, 1);
    adv(10);
    check("rpt_t50_en", u_if.en, 1);
    adv(40);
    u_if.PB_n = 1'b1;
    adv(20);
    check("rpt_count", en_count, snap_e + 6);
    check("rpt_cnt", u_if.cnt, 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
